// File: rtl/soc_system_pio_led_pwm.sv
// Avalon-MM LED output PIO with atomic set/clear/toggle and optional PWM dimming.
// Ports: clk, reset (async, active-high), address[2:0], chipselect, write_n,
//   writedata[31:0], readdata[31:0] (comb, zero wait), out_port[WIDTH-1:0] (reg).
// Build macro SOC_SYSTEM_PIO_LED_PWM_EN adds MODE/PRESCALE/DUTY and the PWM engine.
module soc_system_pio_led_pwm #(
    parameter int WIDTH      = 10,
    parameter int PRESCALE_W = 16,
    parameter int DUTY_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic             wr;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] next_out;

    // Only the low bits of writedata reach any register.
    logic unused_wd;
    assign unused_wd = &{1'b0, writedata};

    assign wr = chipselect & ~write_n;
    assign wd = writedata[WIDTH-1:0];

    always_comb begin
        data_d = data_q;
        if (wr) begin
            case (address)
                3'd0:    data_d = wd;
                3'd4:    data_d = data_q | wd;
                3'd5:    data_d = data_q & ~wd;
                3'd6:    data_d = data_q ^ wd;
                default: data_d = data_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) data_q <= '0;
        else       data_q <= data_d;
    end

`ifdef SOC_SYSTEM_PIO_LED_PWM_EN
    logic [WIDTH-1:0]      mode_q;
    logic [PRESCALE_W-1:0] prescale_q;
    logic [DUTY_W-1:0]     duty_q;
    logic [PRESCALE_W-1:0] pre_cnt_q;
    logic [DUTY_W-1:0]     phase_q;
    logic                  tick;
    logic                  pwm_on;
    logic                  wr_prescale;

    assign wr_prescale = wr && (address == 3'd2);
    assign tick        = (pre_cnt_q == prescale_q);
    assign pwm_on      = (phase_q < duty_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q     <= '0;
            prescale_q <= '0;
            duty_q     <= '0;
        end else if (wr) begin
            if (address == 3'd1) mode_q     <= wd;
            if (address == 3'd2) prescale_q <= writedata[PRESCALE_W-1:0];
            if (address == 3'd3) duty_q     <= writedata[DUTY_W-1:0];
        end
    end

    // A PRESCALE write restarts the period and takes priority over a tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt_q <= '0;
            phase_q   <= '0;
        end else if (wr_prescale) begin
            pre_cnt_q <= '0;
            phase_q   <= '0;
        end else if (tick) begin
            pre_cnt_q <= '0;
            phase_q   <= phase_q + DUTY_W'(1);
        end else begin
            pre_cnt_q <= pre_cnt_q + PRESCALE_W'(1);
        end
    end

    // PWM bits keep DATA as an enable, gated by the shared duty compare.
    assign next_out = data_q & (~mode_q | {WIDTH{pwm_on}});
`else
    localparam int unused_params = PRESCALE_W + DUTY_W;
    assign next_out = data_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) out_port <= '0;
        else       out_port <= next_out;
    end

    always_comb begin
        readdata = '0;
        case (address)
            3'd0:    readdata = 32'(data_q);
`ifdef SOC_SYSTEM_PIO_LED_PWM_EN
            3'd1:    readdata = 32'(mode_q);
            3'd2:    readdata = 32'(prescale_q);
            3'd3:    readdata = 32'(duty_q);
`endif
            3'd7:    readdata = 32'(out_port);
            default: readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_soc_system_pio_led_pwm.sv
// Self-checking bench for soc_system_pio_led_pwm (default parameters).
// Vector table for DATA/set/clear/toggle, hand sequences for PWM and reset.
module tb_soc_system_pio_led_pwm;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [9:0]  out_port;

    int n_cmp = 0;
    int n_bad = 0;

    soc_system_pio_led_pwm dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] wd;
        logic [9:0]  exp_out;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Write is sampled at the posedge between the two negedges.
    task automatic do_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a;
        writedata = d;
        chipselect = 1'b1;
        write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n = 1'b1;
    endtask

    task automatic do_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a;
        chipselect = 1'b1;
        write_n = 1'b1;
        #1 d = readdata;
        chipselect = 1'b0;
    endtask

    task automatic count_high(input int cycles, output int hi, output logic [9:0] acc);
        hi = 0;
        acc = '0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (out_port[0]) hi++;
            acc = acc | out_port;
        end
    endtask

    task automatic wait_rise(output int cyc, output bit ok);
        logic prev;
        prev = out_port[0];
        ok = 1'b0;
        cyc = 0;
        for (int c = 1; c <= 2048 && !ok; c++) begin
            @(negedge clk);
            if (out_port[0] && !prev) begin
                ok = 1'b1;
                cyc = c;
            end
            prev = out_port[0];
        end
    endtask

    initial begin
        logic [31:0] rd;
        int          hi;
        int          cyc;
        bit          ok;
        logic [9:0]  acc;

        vecs[0] = '{3'd0, 32'h0000_03FF, 10'h3FF};
        vecs[1] = '{3'd0, 32'h0000_000F, 10'h00F};
        vecs[2] = '{3'd4, 32'h0000_0300, 10'h30F};
        vecs[3] = '{3'd5, 32'h0000_0005, 10'h30A};
        vecs[4] = '{3'd6, 32'h0000_03FF, 10'h0F5};
        vecs[5] = '{3'd4, 32'hFFFF_FC00, 10'h0F5};
        vecs[6] = '{3'd5, 32'hFFFF_FC00, 10'h0F5};
        vecs[7] = '{3'd7, 32'h0000_03FF, 10'h0F5};
        vecs[8] = '{3'd6, 32'hFFFF_FC0F, 10'h0FA};

        repeat (3) @(negedge clk);
        check("reset out_port", 32'(out_port), 32'h0);
        reset = 1'b0;
        for (int a = 0; a < 8; a++) begin
            do_read(3'(a), rd);
            check($sformatf("reset read addr%0d", a), rd, 32'h0);
        end

        for (int i = 0; i < 9; i++) begin
            do_write(vecs[i].addr, vecs[i].wd);
            check($sformatf("vec%0d out_port before N+1", i), 32'(out_port),
                  (i == 0) ? 32'h0 : 32'(vecs[i-1].exp_out));
            @(negedge clk);
            check($sformatf("vec%0d out_port", i), 32'(out_port), 32'(vecs[i].exp_out));
            do_read(3'd0, rd);
            check($sformatf("vec%0d read DATA", i), rd, 32'(vecs[i].exp_out));
            do_read(3'd7, rd);
            check($sformatf("vec%0d read OUTSTATE", i), rd, 32'(vecs[i].exp_out));
        end
        for (int a = 4; a < 7; a++) begin
            do_read(3'(a), rd);
            check($sformatf("read wo addr%0d", a), rd, 32'h0);
        end

`ifdef SOC_SYSTEM_PIO_LED_PWM_EN
        for (int a = 1; a < 4; a++) begin
            do_write(3'(a), 32'h0000_00FF);
            do_read(3'(a), rd);
            check($sformatf("readback addr%0d", a), rd, 32'h0000_00FF);
        end
        do_write(3'd1, 32'h0);
        do_write(3'd0, 32'h001);
        do_write(3'd1, 32'h001);
        do_write(3'd2, 32'd3);
        do_write(3'd3, 32'd64);
        repeat (4) @(negedge clk);
        count_high(1024, hi, acc);
        check("duty64 high cycles", 32'(hi), 32'd256);
        check("duty64 upper bits", 32'(acc & 10'h3FE), 32'h0);
        wait_rise(cyc, ok);
        check("duty64 first rise found", 32'(ok), 32'd1);
        wait_rise(cyc, ok);
        check("duty64 period", ok ? 32'(cyc) : 32'hFFFF_FFFF, 32'd1024);

        do_write(3'd3, 32'd0);
        repeat (2) @(negedge clk);
        count_high(2048, hi, acc);
        check("duty0 high cycles", 32'(hi), 32'd0);

        do_write(3'd3, 32'd255);
        repeat (2) @(negedge clk);
        count_high(1024, hi, acc);
        check("duty255 low cycles", 32'(1024 - hi), 32'd4);

        // Bit0 is on only in phase 0; the second PRESCALE write lands on the tick.
        do_write(3'd3, 32'd1);
        do_write(3'd2, 32'd3);
        repeat (2) @(negedge clk);
        do_write(3'd2, 32'd3);
        check("restart hold n4", 32'(out_port), 32'h1);
        for (int k = 5; k <= 8; k++) begin
            @(negedge clk);
            check($sformatf("restart hold n%0d", k), 32'(out_port), 32'h1);
        end
        @(negedge clk);
        check("restart next tick", 32'(out_port), 32'h0);
`else
        do_write(3'd0, 32'h055);
        for (int a = 1; a < 4; a++) begin
            do_write(3'(a), 32'h0000_00FF);
            do_read(3'(a), rd);
            check($sformatf("macro off read addr%0d", a), rd, 32'h0);
        end
        check("macro off out_port", 32'(out_port), 32'h055);
        do_read(3'd7, rd);
        check("macro off OUTSTATE", rd, 32'h055);
        do_write(3'd6, 32'h0F0);
        @(negedge clk);
        check("macro off toggle", 32'(out_port), 32'h0A5);
`endif

        @(negedge clk);
        #2 reset = 1'b1;
        #1 check("async reset out_port", 32'(out_port), 32'h0);
        for (int a = 0; a < 8; a++) begin
            do_read(3'(a), rd);
            check($sformatf("mid reset read addr%0d", a), rd, 32'h0);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("post reset out_port", 32'(out_port), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/soc_system_pio_led_pwm.md
# soc_system_pio_led_pwm

Parametrised Avalon-MM output PIO that drives the board LED bank from the HPS lightweight bridge. It succeeds the fixed 10-bit LED PIO: width is configurable, and atomic set, clear and toggle apply to any subset of bits. It adds an optional per-bit PWM dimming engine with a shared prescaler and duty register. The block sits between the Avalon-MM interconnect and the top-level LED pins.

## Interface
Parameters:
- WIDTH, 10, number of output bits (1..32)
- PRESCALE_W, 16, prescaler register/counter width (1..32)
- DUTY_W, 8, PWM duty and phase width (1..16)

Ports:
- clk  in  1  system clock; one clock domain
- reset  in  1  asynchronous, active-high reset
- address  in  3  Avalon word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data, combinational from address, zero wait states
- out_port  out  WIDTH  registered LED drive

## Operation
- A write occurs when chipselect=1 and write_n=0. It uses writedata[WIDTH-1:0] (or the register's own width); upper bits are ignored.
- Register map (address: name, access):
  - 0: DATA, R/W. Static level; enable mask for PWM bits.
  - 1: MODE, R/W. Per bit: 0 = static, 1 = PWM.
  - 2: PRESCALE, R/W, PRESCALE_W bits. A write also clears the prescaler and phase counters.
  - 3: DUTY, R/W, DUTY_W bits.
  - 4: OUTSET, W. DATA <= DATA | wd. Reads return 0.
  - 5: OUTCLEAR, W. DATA <= DATA & ~wd. Reads return 0.
  - 6: OUTTOGGLE, W. DATA <= DATA ^ wd. Reads return 0.
  - 7: OUTSTATE, R. Returns the current out_port; writes are ignored.
- Reads are zero-extended to 32 bits.
- Prescaler counter (PRESCALE_W bits):
  - Counts 0..PRESCALE.
  - Emits a one-cycle tick when the count equals PRESCALE, then reloads 0.
  - PRESCALE=0 gives a tick every cycle.
- Phase counter (DUTY_W bits) increments on each tick and wraps from 2^DUTY_W-1 to 0.
- Per-bit next output:
  - MODE[i]=0: DATA[i].
  - MODE[i]=1: DATA[i] & (phase < DUTY), unsigned compare.
  - DUTY=0 means the bit is always off. The maximum DUTY gives (2^DUTY_W-1)/2^DUTY_W on-time.
- out_port is registered every cycle from the next-output function.
- Reset values: DATA, MODE, PRESCALE, DUTY, both counters and out_port are all 0. readdata follows address (0 after reset).
- Boundaries:
  - A PRESCALE write in the same cycle as a tick: the clear wins, so the phase does not advance.
  - A DUTY write does not disturb the counters. The new duty applies from the next cycle.
  - Writes to the read-only address 7 and to undefined bits are no-ops.
  - Reset asserted mid-period forces all state to 0 immediately (asynchronous). Operation restarts at phase 0 on the first edge after reset deasserts.

## Timing
- Write at edge N updates the register at edge N. The out_port effect appears at edge N+1 (2-edge write-to-pin latency).
- Read: readdata is valid in the same cycle as address/chipselect (readLatency 0). A read of OUTSTATE shows out_port as of the current cycle.
- PWM period = (PRESCALE+1) x 2^DUTY_W cycles.
- The tick asserts in the cycle the count equals PRESCALE. Phase changes on that edge, and out_port reflects the new phase one edge later.

## Configuration
- Macro SOC_SYSTEM_PIO_LED_PWM_EN.
- Defined: prescaler, phase counter, MODE/PRESCALE/DUTY registers and PWM gating are all present, as described above.
- Undefined:
  - No counters and no MODE/PRESCALE/DUTY storage.
  - Addresses 1-3 read 0 and writes to them are ignored.
  - out_port is DATA registered, with the same one-edge latency.
  - Set, clear, toggle and OUTSTATE still function.

## Test plan
- Reset and DATA: assert reset mid-run, then release, and check all outputs and readbacks are 0. Write addr0=0x3FF, then verify out_port=0x3FF at edge N+1 and addr0 reads 0x3FF.
- Set/clear/toggle on DATA=0x00F:
  - OUTSET 0x300 gives 0x30F.
  - OUTCLEAR 0x005 gives 0x30A.
  - OUTTOGGLE 0x3FF gives 0x0F5.
  - addr4/5/6 read 0; upper writedata bits 0xFFFFFC00 have no effect.
- PWM duty: set DATA=0x001, MODE=0x001, PRESCALE=3, DUTY=64 (DUTY_W=8). Require:
  - period = 1024 cycles;
  - bit0 high for exactly 256 cycles per period;
  - bits 1-9 stay 0.
- PWM extremes: with DUTY=0, bit0 is never high over 2 periods. With DUTY=255, it is low for exactly PRESCALE+1 cycles per period.
- Counter restart: write PRESCALE on the cycle its tick asserts. The phase holds at 0 and the next tick arrives PRESCALE+1 cycles after the write edge.
- Macro off: a build without SOC_SYSTEM_PIO_LED_PWM_EN, with writes of 0xFF to addrs 1-3, reads back 0. out_port follows DATA only, and OUTSTATE equals DATA.
